// File: rtl/fx_arb.sv
// Two-master arbiter/sequencer for the shared fx register bus, one single-beat access at a time.
// Define FX_ARB_PRIO_EN for fixed priority (m0 wins ties); default build is round-robin.
module fx_arb #(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] fx_waddr,
  output logic          fx_wr,
  output logic [DW-1:0] fx_data,
  output logic [AW-1:0] fx_raddr,
  output logic          fx_rd,
  input  logic [DW-1:0] fx_q,
  output logic          fx_busy
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, ACK} state_t;

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          wr_q, wr_d, rd_q, rd_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;

  logic          any_req;
  logic          sel;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign any_req = m0_req | m1_req;

`ifdef FX_ARB_PRIO_EN
  assign sel = ~m0_req;
`else
  logic ptr_q, ptr_d;

  // ptr_q remembers the last granted master; a tie goes to the other one
  assign sel = (m0_req && m1_req) ? ~ptr_q : m1_req;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && any_req) ptr_d = sel;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) ptr_q <= 1'b1;
    else     ptr_q <= ptr_d;
  end
`endif

  assign sel_we    = sel ? m1_we    : m0_we;
  assign sel_addr  = sel ? m1_addr  : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    data_d   = data_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d = sel;
          if (sel_we) begin
            state_d = WR;
            waddr_d = sel_addr;
            data_d  = sel_wdata;
            wr_d    = 1'b1;
          end else begin
            state_d = RD;
            raddr_d = sel_addr;
            rd_d    = 1'b1;
          end
        end
      end
      WR: begin
        state_d = ACK;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
      end
      RD: begin
        state_d = RD_WAIT;
        cnt_d   = CNT_INIT;
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          if (gnt_q) rdata1_d = fx_q;
          else       rdata0_d = fx_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and acks are flopped one state ahead so they line up with WR/RD/ACK
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      cnt_q    <= 4'd0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      data_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      data_q   <= data_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

  assign fx_waddr = waddr_q;
  assign fx_raddr = raddr_q;
  assign fx_data  = data_q;
  assign fx_wr    = wr_q;
  assign fx_rd    = rd_q;
  assign m0_ack   = ack0_q;
  assign m1_ack   = ack1_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign fx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_fx_arb.sv
// Testbench for fx_arb: two behavioural masters with queued random transactions,
// checked every cycle against a transaction-timing reference model.
module tb_fx_arb;

  localparam int AW     = 16;
  localparam int DW     = 8;
  localparam int RD_LAT = 2;

  logic          clk_sys = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] fx_waddr, fx_raddr;
  logic          fx_wr, fx_rd, fx_busy;
  logic [DW-1:0] fx_data, fx_q;

  fx_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
    .fx_raddr(fx_raddr), .fx_rd(fx_rd), .fx_q(fx_q), .fx_busy(fx_busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          early;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  logic req_m[2];
  logic out_m[2];
  txn_t cur_m[2];

  // Reference model: the active transaction, its grant cycle, and what each output should hold
  logic          act;
  int            t0;
  int            who;
  txn_t          mt;
  logic          last;
  logic [DW-1:0] exp_rdata[2];
  logic [AW-1:0] exp_waddr, exp_raddr;
  logic [DW-1:0] exp_data;

  int            cyc;
  int            vectors;
  int            miscompares;
  logic          fixed_q_en;
  logic [DW-1:0] fixed_q;

  function automatic txn_t mk(input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic early);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data; t.early = early;
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    m0_req   = req_m[0];
    m0_we    = cur_m[0].we;
    m0_addr  = cur_m[0].addr;
    m0_wdata = cur_m[0].data;
    m1_req   = req_m[1];
    m1_we    = cur_m[1].we;
    m1_addr  = cur_m[1].addr;
    m1_wdata = cur_m[1].data;
  endtask

  task automatic model_reset();
    act = 1'b0; t0 = 0; who = 0; last = 1'b1;
    mt = mk(1'b0, '0, '0, 1'b0);
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_waddr = '0; exp_raddr = '0; exp_data = '0;
    q0.delete(); q1.delete();
    for (int m = 0; m < 2; m++) begin
      req_m[m] = 1'b0; out_m[m] = 1'b0; cur_m[m] = mk(1'b0, '0, '0, 1'b0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_busy"}, fx_busy, 0);
    checkOutput({tag, "_wr"}, fx_wr, 0);
    checkOutput({tag, "_rd"}, fx_rd, 0);
    checkOutput({tag, "_ack0"}, m0_ack, 0);
    checkOutput({tag, "_ack1"}, m1_ack, 0);
    checkOutput({tag, "_rdata0"}, m0_rdata, 0);
    checkOutput({tag, "_rdata1"}, m1_rdata, 0);
    checkOutput({tag, "_waddr"}, fx_waddr, 0);
    checkOutput({tag, "_raddr"}, fx_raddr, 0);
    checkOutput({tag, "_data"}, fx_data, 0);
  endtask

  // One clock cycle: check this cycle's outputs, run the masters, then advance the model
  task automatic applyStimulus();
    int   k, len;
    logic exp_ack[2];
    logic exp_wr, exp_rd, exp_busy, sel;
    @(negedge clk_sys);
    k   = cyc - t0;
    len = mt.we ? 2 : 2 + RD_LAT;
    if (act && k > len) act = 1'b0;
    exp_wr     = act && mt.we && k == 1;
    exp_rd     = act && !mt.we && k == 1;
    exp_ack[0] = act && who == 0 && k == len;
    exp_ack[1] = act && who == 1 && k == len;
    exp_busy   = act && k >= 1;

    checkOutput("fx_wr", fx_wr, exp_wr);
    checkOutput("fx_rd", fx_rd, exp_rd);
    checkOutput("fx_busy", fx_busy, exp_busy);
    checkOutput("m0_ack", m0_ack, exp_ack[0]);
    checkOutput("m1_ack", m1_ack, exp_ack[1]);
    checkOutput("m0_rdata", m0_rdata, exp_rdata[0]);
    checkOutput("m1_rdata", m1_rdata, exp_rdata[1]);
    checkOutput("fx_waddr", fx_waddr, exp_waddr);
    checkOutput("fx_data", fx_data, exp_data);
    checkOutput("fx_raddr", fx_raddr, exp_raddr);

    for (int m = 0; m < 2; m++) begin
      if (exp_ack[m]) begin
        req_m[m] = 1'b0;
        out_m[m] = 1'b0;
      end else if (act && who == m && k == 1 && cur_m[m].early) begin
        req_m[m] = 1'b0;
      end else if (!out_m[m]) begin
        if (m == 0 && q0.size() > 0) begin
          cur_m[0] = q0.pop_front(); out_m[0] = 1'b1; req_m[0] = 1'b1;
        end else if (m == 1 && q1.size() > 0) begin
          cur_m[1] = q1.pop_front(); out_m[1] = 1'b1; req_m[1] = 1'b1;
        end
      end
    end

    fx_q = fixed_q_en ? fixed_q : DW'($urandom);
    if (act && !mt.we && k == 1 + RD_LAT) exp_rdata[who] = fx_q;

    if (!act && (req_m[0] || req_m[1])) begin
`ifdef FX_ARB_PRIO_EN
      sel = !req_m[0];
`else
      if (req_m[0] && req_m[1]) sel = !last;
      else                      sel = req_m[1];
`endif
      last = sel;
      who  = sel ? 1 : 0;
      mt   = cur_m[who];
      act  = 1'b1;
      t0   = cyc;
      if (mt.we) begin
        exp_waddr = mt.addr;
        exp_data  = mt.data;
      end else begin
        exp_raddr = mt.addr;
      end
    end

    drive_inputs();
    cyc++;
  endtask

  task automatic run_until_idle(input string tag);
    int guard = 0;
    while ((act || out_m[0] || out_m[1] || q0.size() > 0 || q1.size() > 0) && guard < 300) begin
      applyStimulus();
      guard++;
    end
    checkOutput({tag, "_drain_timeout"}, guard >= 300, 0);
    applyStimulus();
    applyStimulus();
  endtask

  initial begin
    int   guard;
    logic reached;
    vectors = 0; miscompares = 0; cyc = 0;
    fixed_q_en = 1'b0; fixed_q = '0; fx_q = '0;
    model_reset();
    drive_inputs();
    rst = 1'b1;
    @(negedge clk_sys);
    check_reset_values("reset");
    @(negedge clk_sys);
    rst = 1'b0;

    // Tie right after reset: m0, m1, m0, m1 under round-robin
    q0.push_back(mk(1'b1, 16'h0100, 8'h11, 1'b0));
    q0.push_back(mk(1'b0, 16'h0101, 8'h00, 1'b0));
    q1.push_back(mk(1'b1, 16'h0200, 8'h22, 1'b0));
    q1.push_back(mk(1'b0, 16'h0201, 8'h00, 1'b0));
    run_until_idle("tie");

    q0.push_back(mk(1'b1, 16'h0010, 8'hA5, 1'b0));
    run_until_idle("m0_write");

    fixed_q_en = 1'b1; fixed_q = 8'h3C;
    q1.push_back(mk(1'b0, 16'h0020, 8'h00, 1'b0));
    run_until_idle("m1_read");
    fixed_q_en = 1'b0;

    q0.push_back(mk(1'b1, 16'h0030, 8'h5A, 1'b1));
    q0.push_back(mk(1'b0, 16'h0031, 8'h00, 1'b1));
    run_until_idle("early_drop");

    // Reset while m1's read sits in RD_WAIT
    q1.push_back(mk(1'b0, 16'h0044, 8'h00, 1'b0));
    guard = 0; reached = 1'b0;
    while (!reached && guard < 50) begin
      applyStimulus();
      guard++;
      reached = act && !mt.we && (cyc - 1 - t0) == 2;
    end
    checkOutput("rdwait_reached", reached, 1);
    #2 rst = 1'b1;
    #1 check_reset_values("midrst");
    model_reset();
    drive_inputs();
    @(negedge clk_sys);
    check_reset_values("midrst_hold");
    rst = 1'b0;
    q1.push_back(mk(1'b0, 16'h0055, 8'h00, 1'b0));
    run_until_idle("after_rst");

    for (int i = 0; i < 500; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 2) == 0)
        q0.push_back(mk(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                        $urandom_range(0, 7) == 0));
      if (q1.size() == 0 && $urandom_range(0, 2) == 0)
        q1.push_back(mk(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                        $urandom_range(0, 7) == 0));
      applyStimulus();
    end
    run_until_idle("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
